rc5_key_load: RTL

RC5_KEY_LOAD -- requirements
Module: rc5_key_load

---
 rtl/rc5_pkg.sv | 9 +
 rtl/rc5_rotl_add.sv | 12 +
 rtl/rc5_key_load.sv | 108 ++++++++++
 3 files changed

// File: rtl/rc5_pkg.sv
// rc5_pkg: shared FSM encoding and rotate helper for the RC5 key loader.
package rc5_pkg;
    typedef enum logic [2:0] {IDLE, CLEAR, READ, OPERATE, WRITE, DONE} state_t;
    localparam int RC5_MAX_W = 256;
    // Operands arrive zero-extended to RC5_MAX_W; only the low w bits of the result are meaningful.
    function automatic logic [RC5_MAX_W-1:0] rotl8(input logic [RC5_MAX_W-1:0] x, input int w);
        return (x << 8) | (x >> (w - 8));
    endfunction
endpackage

// File: rtl/rc5_rotl_add.sv
// rc5_rotl_add: combinational L word update, rotl(L, 8) plus a zero-extended key byte mod 2^W.
module rc5_rotl_add
    import rc5_pkg::*;
#(
    parameter int W = 32
) (
    input  logic [W-1:0] l_i,
    input  logic [7:0]   key_i,
    output logic [W-1:0] sum_o
);
    assign sum_o = W'(rotl8(RC5_MAX_W'(l_i), W)) + W'(key_i);
endmodule

// File: rtl/rc5_key_load.sv
// rc5_key_load: RC5 key expansion front end, packs key bytes into the L word array.
// Define RC5_KEY_CLEAR_EN to zero L before loading; otherwise existing L contents are folded in.
module rc5_key_load
    import rc5_pkg::*;
#(
    parameter int B = 16,
    parameter int W = 32,
    localparam int U = W / 8,
    localparam int C = (B + U - 1) / U,
    localparam int B_LEN = (B > 1) ? $clog2(B) : 1,
    localparam int C_LEN = (C > 1) ? $clog2(C) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [B_LEN-1:0] key_address,
    input  logic [7:0]       key_sub_i,
    output logic [C_LEN-1:0] L_address,
    input  logic [W-1:0]     L_sub_i,
    output logic [W-1:0]     L_sub_i_prima,
    output logic             L_we
);
    state_t           state_q;
    logic [B_LEN-1:0] count_q, key_q;
    logic [C_LEN-1:0] la_q;
    logic [W-1:0]     lp_q, l_prima_d;
    logic             we_q, done_q, busy_q;

    function automatic logic [C_LEN-1:0] word_of(input logic [B_LEN-1:0] k);
        return C_LEN'(k / U);
    endfunction

    rc5_rotl_add #(.W(W)) u_rotl_add (
        .l_i  (L_sub_i),
        .key_i(key_sub_i),
        .sum_o(l_prima_d)
    );

    // Bytes are folded from the highest index down so each word ends up little-endian packed.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            count_q <= B_LEN'(B - 1);
            key_q   <= '0;
            la_q    <= '0;
            lp_q    <= '0;
            we_q    <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            we_q   <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                IDLE: if (start) begin
                    busy_q  <= 1'b1;
                    count_q <= B_LEN'(B - 1);
`ifdef RC5_KEY_CLEAR_EN
                    state_q <= CLEAR;
                    la_q    <= '0;
                    lp_q    <= '0;
                    we_q    <= 1'b1;
`else
                    state_q <= READ;
                    key_q   <= B_LEN'(B - 1);
                    la_q    <= word_of(B_LEN'(B - 1));
`endif
                end
                CLEAR: if (la_q == C_LEN'(C - 1)) begin
                    state_q <= READ;
                    key_q   <= count_q;
                    la_q    <= word_of(count_q);
                end else begin
                    la_q <= la_q + 1'b1;
                    we_q <= 1'b1;
                end
                READ: state_q <= OPERATE;
                OPERATE: begin
                    lp_q    <= l_prima_d;
                    we_q    <= 1'b1;
                    state_q <= WRITE;
                end
                WRITE: if (count_q == '0) begin
                    state_q <= DONE;
                    done_q  <= 1'b1;
                end else begin
                    count_q <= count_q - 1'b1;
                    key_q   <= count_q - 1'b1;
                    la_q    <= word_of(count_q - 1'b1);
                    state_q <= READ;
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign key_address   = key_q;
    assign L_address     = la_q;
    assign L_sub_i_prima = lp_q;
    assign L_we          = we_q;
endmodule
